// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB/TRAP with a retired-instruction counter.
// Optional memory wait states are enabled by defining MULTICYCLE_CTRL_MEM_WAIT_EN.
module multicycle_ctrl #(
  parameter logic TRAP_HOLD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        iord,
  output logic        reg_we,
  output logic        reg_dst,
  output logic        wb_sel,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                         A_SLT = 4'd4, A_SLL = 4'd5, A_SRL = 4'd6;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic [5:0]  op, funct;
  logic        is_r, is_shift, mem_ok, retire_inc;
  logic        unused_sig;

  function automatic logic op_legal(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_R:                                           op_legal = f inside {F_SLL, F_SRL, F_ADD, F_ADDU,
                                                                           F_SUB, F_AND, F_OR, F_SLT};
      OP_J, OP_BEQ, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_sel(input logic [5:0] o, input logic [5:0] f);
    alu_sel = A_ADD;
    if (o == OP_BEQ) alu_sel = A_SUB;
    else if (o == OP_R) begin
      case (f)
        F_SUB:   alu_sel = A_SUB;
        F_AND:   alu_sel = A_AND;
        F_OR:    alu_sel = A_OR;
        F_SLT:   alu_sel = A_SLT;
        F_SLL:   alu_sel = A_SLL;
        F_SRL:   alu_sel = A_SRL;
        default: alu_sel = A_ADD;
      endcase
    end
  endfunction

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign is_r     = (op == OP_R);
  assign is_shift = is_r && ((funct == F_SLL) || (funct == F_SRL));

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ok     = mem_ready;
  assign unused_sig = ^instr[25:6];
`else
  assign mem_ok     = 1'b1;
  assign unused_sig = ^{mem_ready, instr[25:6]};
`endif

  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    iord      = 1'b0;
    reg_we    = 1'b0;
    reg_dst   = 1'b0;
    wb_sel    = 1'b0;
    pc_src    = 2'b00;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_op    = A_ADD;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is written in the same cycle the IR captures the word
        mem_rd    = 1'b1;
        ir_we     = mem_ok;
        pc_we     = mem_ok;
        alu_src_b = 2'b01;
        state_d   = mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if (op == OP_J) begin
          pc_we   = 1'b1;
          pc_src  = 2'b10;
          state_d = S_FETCH;
        end else if (!op_legal(op, funct)) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = is_shift ? 2'b10 : 2'b01;
        alu_src_b = (is_r || op == OP_BEQ) ? 2'b00 : 2'b10;
        alu_op    = alu_sel(op, funct);
        if (op == OP_BEQ) begin
          pc_we   = zero;
          pc_src  = 2'b01;
          state_d = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (op == OP_LW) begin
          mem_rd  = 1'b1;
          state_d = mem_ok ? S_WB : S_MEM;
        end else begin
          mem_wr  = mem_ok;
          state_d = mem_ok ? S_FETCH : S_MEM;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        reg_dst = is_r;
        wb_sel  = (op == OP_LW);
        state_d = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = TRAP_HOLD ? S_TRAP : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only completed instructions count; TRAP re-entry to FETCH is not a retirement
  always_comb begin
    retire_inc = (state_d == S_FETCH) &&
                 (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    retired_d  = retired_q + 32'(retire_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter TRAP_HOLD, default 1, meaning an illegal opcode parks the FSM in TRAP until reset (0: skip the instruction and fetch the next).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port instr, input, 32 bits, the current IR contents, valid from DECODE onward.
REQ-005 The block SHALL have port zero, input, 1 bit, the ALU zero flag from the datapath.
REQ-006 The block SHALL have port mem_ready, input, 1 bit, the memory-done strobe (used only under REQ-027).
REQ-007 The block SHALL have ports pc_we, ir_we, mem_rd, mem_wr, iord, reg_we, reg_dst, wb_sel, all outputs of 1 bit, as the datapath write enables and 2:1 selects.
REQ-008 The block SHALL have ports pc_src, alu_src_a and alu_src_b, outputs of 2 bits each, as the datapath 3/4:1 selects.
REQ-009 The block SHALL have ports alu_op, output, 4 bits; state, output, 3 bits; illegal, output, 1 bit; retired, output, 32 bits.

Function
REQ-010 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; the state output equals the state register.
REQ-011 Outputs SHALL be combinational from the state register and instr only, with no combinational path from mem_ready or zero except pc_we in EXEC.
REQ-012 FETCH SHALL assert mem_rd=1, iord=0, ir_we=1, pc_we=1, pc_src=00, alu_src_a=00 (PC), alu_src_b=01 (+4), alu_op=ADD, then go to DECODE.
REQ-013 DECODE SHALL assert alu_src_a=00, alu_src_b=11 (sext(imm)<<2), alu_op=ADD (branch target precompute); on j (op 0x02) it asserts pc_we=1, pc_src=10 and goes to FETCH; on an unsupported op it goes to TRAP; otherwise it goes to EXEC.
REQ-014 The supported set SHALL be R-type (op 0) funct add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02; addi 0x08, addiu 0x09, lw 0x23, sw 0x2B, beq 0x04, j 0x02; any other op or R-type funct is illegal.
REQ-015 alu_op SHALL be encoded ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6; add/addu/addi/addiu/lw/sw use ADD, and beq uses SUB.
REQ-016 EXEC SHALL use alu_src_a=01 (rs) for all but sll/srl (10, shamt, with operand B=rt), alu_src_b=00 (rt) for R-type/beq and 10 (sext imm) for I-type.
REQ-017 EXEC transitions SHALL be: R-type/addi/addiu -> WB; lw/sw -> MEM; beq -> FETCH with pc_we=zero and pc_src=01.
REQ-018 MEM SHALL assert iord=1 with mem_rd=1 (lw, -> WB) or mem_wr=1 (sw, -> FETCH).
REQ-019 WB SHALL assert reg_we=1, with reg_dst=1 (rd) for R-type and 0 (rt) otherwise, and wb_sel=1 for lw and 0 otherwise, then go to FETCH.
REQ-020 Latency SHALL be: j 2 cycles, beq 3, R-type/addi/addiu/sw 4, lw 5 (with no wait states).
REQ-021 retired SHALL increment by 1, wrapping 0xFFFFFFFF to 0, on every transition into FETCH from DECODE/EXEC/MEM/WB; entry from TRAP does not increment it.
REQ-022 In TRAP, illegal=1 and all write enables SHALL be 0; the FSM stays in TRAP if TRAP_HOLD=1 and otherwise goes to FETCH after one cycle (PC is already advanced).
REQ-023 All write enables and mem_rd SHALL be 0 in any state where not listed above, and selects default to 0.

Reset
REQ-024 When rst_n=0, the block SHALL asynchronously force state=FETCH, retired=0 and illegal=0.
REQ-025 A reset asserted mid-instruction SHALL abandon that instruction with no retire count, and the first rising edge after release SHALL perform a full FETCH.

Configuration
REQ-026 The macro MULTICYCLE_CTRL_MEM_WAIT_EN SHALL gate memory wait states.
REQ-027 With MULTICYCLE_CTRL_MEM_WAIT_EN defined, FETCH and MEM SHALL hold their state and outputs while mem_ready=0, advance on mem_ready=1, and pulse pc_we/ir_we/mem_wr on the completing cycle only.
REQ-028 Without MULTICYCLE_CTRL_MEM_WAIT_EN, mem_ready SHALL be ignored and FETCH and MEM last exactly one cycle.

Verification
REQ-029 Bench: reset, then instr=0x00000820 (add) -> states 0,1,2,4,0; alu_op=0; reg_we=1 with reg_dst=1 in WB; retired=1.
REQ-030 Bench: 0x2002000A (addi) and 0x2403000A (addiu) -> EXEC alu_src_b=10; WB reg_dst=0, wb_sel=0; 4 cycles each.
REQ-031 Bench: 0x00023080 (sll) -> EXEC alu_src_a=10, alu_op=5; 0x00442824 (and) -> alu_op=2.
REQ-032 Bench: lw 0x8C410004 with MULTICYCLE_CTRL_MEM_WAIT_EN and mem_ready low for 2 cycles in MEM -> MEM held 3 cycles, then WB with wb_sel=1, 7 cycles total.
REQ-033 Bench: beq 0x10220003 with zero=1 -> pc_we=1, pc_src=01 in EXEC; with zero=0 -> pc_we=0; 3 cycles each.
REQ-034 Bench: instr 0xFC000000 -> TRAP with illegal=1, stuck while TRAP_HOLD=1; assert rst_n=0 mid-TRAP -> state=0 and retired=0 immediately.
